// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order requests to a pipelined imem, a DEPTH-entry
// prefetch queue toward decode, and flush on branch/ERET/interrupt redirects.
module fetch_queue #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [ADDR_W-1:0] TEXT_LO   = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] TEXT_HI   = 32'h0000_4ffc
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              d_ready,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_instr,
    output logic [ADDR_W-1:0] d_pc,
    output logic [ADDR_W-1:0] d_pcplus4,
    output logic              d_error
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_q_pc    [DEPTH];
    logic [DATA_W-1:0] r_q_instr [DEPTH];
    logic [DEPTH-1:0]  r_q_err;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_drop;
    logic              r_halted;
    logic [ADDR_W-1:0] r_ipc     [DEPTH];
    logic [PW-1:0]     r_ipc_rd;
    logic [PW-1:0]     r_ipc_wr;

    logic              w_flush;
    logic [ADDR_W-1:0] w_target;
    logic [SW-1:0]     w_used;
    logic              w_credit;
    logic              w_legal;
    logic              w_issue;
    logic              w_err_enq;
    logic              w_rsp_enq;
    logic              w_enq;
    logic              w_pop;
    logic [ADDR_W-1:0] w_enq_pc;
    logic [DATA_W-1:0] w_enq_instr;

    always_comb begin
        w_flush   = irq | redirect_valid;
        w_target  = irq ? EXC_ENTRY : redirect_pc;
        w_used    = {1'b0, r_count} + {1'b0, r_inflight};
        // reset gates the request so all outputs stay low while it is asserted
        w_credit  = reset && !r_halted && !w_flush && (w_used < SW'(DEPTH));
        w_legal   = (r_fetch_pc >= TEXT_LO) && (r_fetch_pc <= TEXT_HI) &&
                    (r_fetch_pc[1:0] == 2'b00);
        w_issue   = w_credit && w_legal;
        // the error entry waits until every older live response has been queued
        w_err_enq = w_credit && !w_legal && (r_inflight == r_drop);
        w_rsp_enq = imem_rvalid && !w_flush && (r_drop == '0);
        w_enq     = w_rsp_enq || w_err_enq;
        w_pop     = d_valid && d_ready && !w_flush;

        w_enq_pc    = w_rsp_enq ? r_ipc[r_ipc_rd] : r_fetch_pc;
        w_enq_instr = w_rsp_enq ? imem_rdata : '0;
    end

    assign imem_req  = w_issue;
    assign imem_addr = w_issue ? r_fetch_pc : '0;

    assign d_valid   = (r_count != '0);
    assign d_pc      = d_valid ? r_q_pc[r_rd_ptr] : '0;
    assign d_pcplus4 = d_valid ? r_q_pc[r_rd_ptr] + ADDR_W'(4) : '0;
    assign d_instr   = d_valid ? r_q_instr[r_rd_ptr] : '0;
    assign d_error   = d_valid && r_q_err[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_halted   <= 1'b0;
            r_ipc_rd   <= '0;
            r_ipc_wr   <= '0;
            r_q_err    <= '0;
        end else begin
            if (w_flush) begin
                r_fetch_pc <= w_target;
                r_halted   <= 1'b0;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                // everything still outstanding after this cycle's response is stale
                r_drop     <= r_inflight - CW'(imem_rvalid);
            end else begin
                if (w_issue)
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                if (w_err_enq)
                    r_halted <= 1'b1;
                if (w_enq) begin
                    r_q_err[r_wr_ptr] <= !w_rsp_enq;
                    r_wr_ptr          <= r_wr_ptr + PW'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_enq) - CW'(w_pop);
                if (imem_rvalid && (r_drop != '0))
                    r_drop <= r_drop - CW'(1);
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(imem_rvalid);
            if (w_issue)
                r_ipc_wr <= r_ipc_wr + PW'(1);
            if (imem_rvalid)
                r_ipc_rd <= r_ipc_rd + PW'(1);
        end
    end

    // payload storage needs no reset; d_* are masked by d_valid
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_pc[r_wr_ptr]    <= w_enq_pc;
            r_q_instr[r_wr_ptr] <= w_enq_instr;
        end
        if (w_issue)
            r_ipc[r_ipc_wr] <= r_fetch_pc;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a variable-latency in-order memory model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pcplus4;
    logic        d_error;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 1;
    int cyc      = 0;
    int bad_req  = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend[$];

    fetch_queue #(
        .ADDR_W(32),
        .DATA_W(32),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq(irq),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .d_ready(d_ready),
        .d_valid(d_valid),
        .d_instr(d_instr),
        .d_pc(d_pc),
        .d_pcplus4(d_pcplus4),
        .d_error(d_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // request accepted at the edge ending cycle c returns during cycle c+lat
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_req) begin
                pend.push_back('{imem_addr, cyc + lat});
                if (imem_addr < 32'h3000 || imem_addr > 32'h4ffc)
                    bad_req = bad_req + 1;
            end
            cyc = cyc + 1;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= instr_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},    imem_req,  0);
        check({tag, "_addr"},   imem_addr, 0);
        check({tag, "_valid"},  d_valid,   0);
        check({tag, "_instr"},  d_instr,   0);
        check({tag, "_pc"},     d_pc,      0);
        check({tag, "_pc4"},    d_pcplus4, 0);
        check({tag, "_err"},    d_error,   0);
    endtask

    task automatic restart(input int l, input logic rdy);
        reset = 1'b0;
        lat   = l;
        tick();
        tick();
        d_ready = rdy;
        reset   = 1'b1;
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        irq            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        d_ready        = 1'b1;

        // reset release, L=1, streaming
        tick();
        tick();
        check_all_zero("rst");
        restart(1, 1'b1);
        check("t1_req0", imem_req, 1);
        check("t1_addr0", imem_addr, 32'h3000);
        tick();
        check("t1_addr1", imem_addr, 32'h3004);
        check("t1_nobypass", d_valid, 0);
        tick();
        check("t1_addr2", imem_addr, 32'h3008);
        check("t1_valid", d_valid, 1);
        check("t1_pc", d_pc, 32'h3000);
        check("t1_pc4", d_pcplus4, 32'h3004);
        check("t1_instr", d_instr, instr_of(32'h3000));
        tick();
        check("t1_pc_next", d_pc, 32'h3004);
        check("t1_valid_next", d_valid, 1);

        // backpressure, L=2
        restart(2, 1'b0);
        check("t2_addr0", imem_addr, 32'h3000);
        tick();
        tick();
        tick();
        check("t2_req3", imem_req, 1);
        check("t2_addr3", imem_addr, 32'h300c);
        tick();
        check("t2_full_req", imem_req, 0);
        repeat (4) tick();
        check("t2_hold_req", imem_req, 0);
        check("t2_hold_valid", d_valid, 1);
        check("t2_hold_pc", d_pc, 32'h3000);
        d_ready = 1'b1;
        #1;
        check("t2_pop_req", imem_req, 0);
        tick();
        d_ready = 1'b0;
        #1;
        check("t2_resume_req", imem_req, 1);
        check("t2_resume_addr", imem_addr, 32'h3010);
        check("t2_resume_pc", d_pc, 32'h3004);
        tick();
        check("t2_refill_req", imem_req, 0);
        check("t2_stall_pc", d_pc, 32'h3004);

        // redirect with two in flight, L=2
        restart(2, 1'b1);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3400;
        #1;
        check("t3_flush_req", imem_req, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t3_req", imem_req, 1);
        check("t3_addr", imem_addr, 32'h3400);
        check("t3_valid0", d_valid, 0);
        tick();
        check("t3_valid1", d_valid, 0);
        tick();
        check("t3_valid2", d_valid, 0);
        tick();
        check("t3_valid3", d_valid, 1);
        check("t3_pc", d_pc, 32'h3400);
        check("t3_instr", d_instr, instr_of(32'h3400));

        // irq and redirect together: irq wins
        irq            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3800;
        #1;
        check("t4_flush_req", imem_req, 0);
        tick();
        irq            = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("t4_req", imem_req, 1);
        check("t4_addr", imem_addr, 32'h4180);
        check("t4_valid0", d_valid, 0);
        tick();
        check("t4_valid1", d_valid, 0);
        tick();
        check("t4_valid2", d_valid, 0);
        tick();
        check("t4_valid3", d_valid, 1);
        check("t4_pc", d_pc, 32'h4180);

        // sequential fetch off the end of the text window
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4ff0;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t5_addr", imem_addr, 32'h4ff0);
        tick();
        check("t5_valid0", d_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_seq_valid", d_valid, 1);
            check("t5_seq_pc", d_pc, 32'h4ff0 + 32'(4 * i));
            check("t5_seq_err", d_error, 0);
            if (i >= 2)
                check("t5_seq_noreq", imem_req, 0);
        end
        tick();
        check("t5_err_valid", d_valid, 1);
        check("t5_err_pc", d_pc, 32'h5000);
        check("t5_err_pc4", d_pcplus4, 32'h5004);
        check("t5_err_flag", d_error, 1);
        check("t5_err_instr", d_instr, 0);
        check("t5_err_noreq", imem_req, 0);
        tick();
        check("t5_drained", d_valid, 0);
        repeat (3) tick();
        check("t5_halted_req", imem_req, 0);
        check("t5_bad_reqs", bad_req, 0);
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t5_restart_req", imem_req, 1);
        check("t5_restart_addr", imem_addr, 32'h3000);

        // reset asserted with three requests outstanding
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_all_zero("t6_rst");
        lat = 1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6_addr", imem_addr, 32'h3000);
        tick();
        check("t6_valid0", d_valid, 0);
        tick();
        check("t6_valid1", d_valid, 1);
        check("t6_pc", d_pc, 32'h3000);
        check("t6_instr", d_instr, instr_of(32'h3000));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
